aurora_link_sequencer: RTL
==========================

Name: aurora_link_sequencer

Overview:
- Bring-up and recovery controller for one Aurora 64b66b lane.
- Drives the core's pma_init and reset_pb in the Xilinx-required order and waits for channel_up.
- Retries on timeout or hard error; reissues a soft reset when the channel drops.
- Sits in the sysClk domain between the CSR/GPIO control bits and the Aurora MGT wrapper, replacing software-timed reset toggling.

Parameters:
- PMA_INIT_CYCLES, 1024: sysClk cycles gtReset (pma_init) is held high per attempt; must be >=1.
- RESET_CYCLES, 128: cycles auroraReset (reset_pb) is held high after gtReset deasserts; must be >=1.
- TIMEOUT_CYCLES, 1048576: max cycles in WAIT_UP for channelUp before a retry; must be >=1.
- DROP_CYCLES, 16: consecutive cycles channelUp must be low in UP before recovery; must be >=1.
- TIMER_WIDTH, 24: width of the dwell timer; must hold max(param)-1.

Ports:
- sysClk, input, 1: sole clock.
- sysReset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: sequencer run; low forces IDLE.
- forceReset, input, 1: single-cycle request to restart from PMA_INIT.
- clearCounts, input, 1: single-cycle clear of retryCount and dropCount.
- channelUp, input, 1: Aurora channel_up, already synchronized to sysClk.
- hardErr, input, 1: Aurora hard_err, already synchronized to sysClk.
- gtPllLock, input, 1: Aurora gt_pll_lock, already synchronized.
- gtReset, output, 1: to pma_init.
- auroraReset, output, 1: to reset_pb.
- linkUp, output, 1: high only in state UP.
- state, output, 3: current state encoding.
- retryCount, output, 8: saturating count of PMA_INIT re-entries caused by timeout or hardErr.
- dropCount, output, 8: saturating count of UP->RESET_HOLD recoveries.

Behaviour:
- Reset (sysReset_n low, async) values:
  - state = IDLE.
  - gtReset = 1, auroraReset = 1, linkUp = 0.
  - retryCount = 0, dropCount = 0, timer = 0, drop counter = 0.
- All outputs are registered and change only on the sysClk rising edge after reset release.
- State encoding: IDLE=0, PMA_INIT=1, RESET_HOLD=2, WAIT_UP=3, UP=4. Values 5-7 are illegal and go to IDLE next cycle.
- Output levels per state:
  - IDLE: gtReset=1, auroraReset=1.
  - PMA_INIT: gtReset=1, auroraReset=1.
  - RESET_HOLD: gtReset=0, auroraReset=1.
  - WAIT_UP: gtReset=0, auroraReset=0.
  - UP: gtReset=0, auroraReset=0, linkUp=1.
- Dwell timer: on entry to a timed state, load N-1; decrement each cycle; leave when timer==0. Dwell is exactly N cycles.
- Transition priority each cycle, highest first:
  1. enable=0: next state IDLE.
  2. forceReset=1: next state PMA_INIT, timer loaded. retryCount is not incremented.
  3. Per-state rules below.
- Per-state rules:
  - IDLE: if enable=1, go to PMA_INIT.
  - PMA_INIT: at timer==0, go to RESET_HOLD only if gtPllLock=1. Otherwise stay in PMA_INIT with timer held at 0 until lock arrives.
  - RESET_HOLD: at timer==0, go to WAIT_UP (timer loaded with TIMEOUT_CYCLES-1).
  - WAIT_UP:
    - channelUp=1: go to UP.
    - else hardErr=1 or timer==0: go to PMA_INIT, retryCount+1.
    - If channelUp and hardErr are both high in the same cycle, channelUp wins.
  - UP:
    - hardErr=1: go to PMA_INIT, retryCount+1.
    - channelUp=0: increment drop counter. When it reaches DROP_CYCLES, go to RESET_HOLD (timer loaded) and dropCount+1.
    - channelUp=1: clear drop counter.
    - hardErr has priority over the drop check.
- Counters:
  - Both saturate at 255.
  - clearCounts zeroes them. If clearCounts coincides with an increment, the result is 0.
- Reset mid-sequence: async assertion returns to reset values immediately, regardless of timer state.

Test Plan (PMA_INIT_CYCLES=4, RESET_CYCLES=3, TIMEOUT_CYCLES=10, DROP_CYCLES=2):
1. Nominal bring-up: release reset, set enable=1 and gtPllLock=1, assert channelUp on the 5th WAIT_UP cycle.
   -> gtReset high for exactly 4 PMA_INIT cycles, then auroraReset high 3 more cycles, then linkUp=1 and state=4 the cycle after channelUp. retryCount=0.
2. Timeout: channelUp held low.
   -> after 10 WAIT_UP cycles state=1 and retryCount=1. After 300 attempts retryCount saturates at 255.
3. Channel drop: in UP, pulse channelUp low for 1 cycle, then hold it low for 2 cycles.
   -> the 1-cycle glitch leaves state=4. The 2-cycle drop gives state=2, dropCount=1, auroraReset high for 3 cycles, then WAIT_UP.
4. Priorities: in WAIT_UP assert channelUp and hardErr together -> state=4. In UP assert enable=0 and forceReset together -> state=0.
5. PLL lock gating: hold gtPllLock=0 through PMA_INIT.
   -> gtReset stays 1 indefinitely. Raising gtPllLock gives state=2 on the next edge.
6. Async reset and counter clear: assert sysReset_n low mid-RESET_HOLD -> outputs take reset values without waiting for a clock edge. clearCounts coinciding with a retry increment -> retryCount=0.

Source files
------------

// File: rtl/aurora_link_sequencer.sv
// Aurora 64b66b lane bring-up/recovery sequencer.
// Orders pma_init and reset_pb, retries on timeout/hard error, recovers drops.
module aurora_link_sequencer #(
  parameter int PMA_INIT_CYCLES = 1024,
  parameter int RESET_CYCLES    = 128,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter int DROP_CYCLES     = 16,
  parameter int TIMER_WIDTH     = 24
) (
  input  logic       sysClk,
  input  logic       sysReset_n,
  input  logic       enable,
  input  logic       forceReset,
  input  logic       clearCounts,
  input  logic       channelUp,
  input  logic       hardErr,
  input  logic       gtPllLock,
  output logic       gtReset,
  output logic       auroraReset,
  output logic       linkUp,
  output logic [2:0] state,
  output logic [7:0] retryCount,
  output logic [7:0] dropCount
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PMA_INIT   = 3'd1,
    RESET_HOLD = 3'd2,
    WAIT_UP    = 3'd3,
    UP         = 3'd4
  } state_t;

  localparam int DW = $clog2(DROP_CYCLES + 1);

  localparam logic [TIMER_WIDTH-1:0] PMA_LOAD =
    TIMER_WIDTH'(PMA_INIT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] RST_LOAD =
    TIMER_WIDTH'(RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TO_LOAD =
    TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DROP_LAST =
    DW'(DROP_CYCLES - 1);

  state_t                 stateQ, stateD;
  logic [TIMER_WIDTH-1:0] timerQ, timerD;
  logic [DW-1:0]          dropQ, dropD;
  logic                   retryInc, dropInc;
  logic [7:0]             retryD, dropCountD;
  logic                   gtResetD, auroraResetD, linkUpD;
  logic                   timerZero;

  assign timerZero = (timerQ == '0);

  always_comb begin
    stateD   = stateQ;
    timerD   = timerZero ? '0 : timerQ - 1'b1;
    dropD    = '0;
    retryInc = 1'b0;
    dropInc  = 1'b0;
    if (!enable) begin
      stateD = IDLE;
      timerD = '0;
    end else if (forceReset) begin
      stateD = PMA_INIT;
      timerD = PMA_LOAD;
    end else begin
      case (stateQ)
        IDLE: begin
          stateD = PMA_INIT;
          timerD = PMA_LOAD;
        end
        PMA_INIT: begin
          // Timer parks at zero until the PLL reports lock.
          if (timerZero && gtPllLock) begin
            stateD = RESET_HOLD;
            timerD = RST_LOAD;
          end
        end
        RESET_HOLD: begin
          if (timerZero) begin
            stateD = WAIT_UP;
            timerD = TO_LOAD;
          end
        end
        WAIT_UP: begin
          if (channelUp) begin
            stateD = UP;
            timerD = '0;
          end else if (hardErr || timerZero) begin
            stateD   = PMA_INIT;
            timerD   = PMA_LOAD;
            retryInc = 1'b1;
          end
        end
        UP: begin
          if (hardErr) begin
            stateD   = PMA_INIT;
            timerD   = PMA_LOAD;
            retryInc = 1'b1;
          end else if (!channelUp) begin
            if (dropQ == DROP_LAST) begin
              stateD  = RESET_HOLD;
              timerD  = RST_LOAD;
              dropInc = 1'b1;
            end else begin
              dropD = dropQ + 1'b1;
            end
          end
        end
        default: begin
          stateD = IDLE;
          timerD = '0;
        end
      endcase
    end
  end

  always_comb begin
    retryD = retryCount;
    if (clearCounts)
      retryD = '0;
    else if (retryInc && retryCount != 8'hFF)
      retryD = retryCount + 8'd1;
  end

  always_comb begin
    dropCountD = dropCount;
    if (clearCounts)
      dropCountD = '0;
    else if (dropInc && dropCount != 8'hFF)
      dropCountD = dropCount + 8'd1;
  end

  // Outputs follow the next state so they are registered alongside it.
  assign gtResetD     = (stateD == IDLE) || (stateD == PMA_INIT);
  assign auroraResetD = (stateD != WAIT_UP) && (stateD != UP);
  assign linkUpD      = (stateD == UP);

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      stateQ      <= IDLE;
      timerQ      <= '0;
      dropQ       <= '0;
      retryCount  <= '0;
      dropCount   <= '0;
      gtReset     <= 1'b1;
      auroraReset <= 1'b1;
      linkUp      <= 1'b0;
    end else begin
      stateQ      <= stateD;
      timerQ      <= timerD;
      dropQ       <= dropD;
      retryCount  <= retryD;
      dropCount   <= dropCountD;
      gtReset     <= gtResetD;
      auroraReset <= auroraResetD;
      linkUp      <= linkUpD;
    end
  end

  assign state = stateQ;

endmodule
